// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - SPI mode-0 slave front end, oversampled in the clk domain
//
// Optional TX path enabled by defining SPI_PERIPHERAL_TX_EN.
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   spi_sclk/cs_n/mosi   asynchronous SPI pins (CPOL=0, CPHA=0)
//   spi_miso             slave-out data
//   rx_valid, rx_byte    one-cycle strobe with the last received byte
//   tx_byte, tx_load     response byte and its load strobe
//   tx_ready             TX buffer empty
//   tx_underrun          pulse: a byte slot started with the TX buffer empty
//   frame_active         high while a frame is in progress
module spi_peripheral #(
  parameter logic [7:0] IDLE_TX_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  input  logic [7:0] tx_byte,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic       frame_active
);

  typedef enum logic [1:0] {
    S_WAIT_IDLE = 2'd0,
    S_IDLE      = 2'd1,
    S_ACTIVE    = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic       r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic       r_cs_s1, r_cs_s2;
  logic       r_mosi_s1, r_mosi_s2;

  logic [7:0] r_rx_shift;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_byte;
  logic       r_rx_valid;

  logic       w_enter;
  logic       w_in_frame;
  logic       w_rise;
  logic       w_fall;

  // cs_n synchroniser resets low so WAIT_IDLE only leaves once the real pin
  // has been seen high through the full chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_cs_s1   <= 1'b0;
      r_cs_s2   <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= spi_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_cs_s1   <= spi_cs_n;
      r_cs_s2   <= r_cs_s1;
      r_mosi_s1 <= spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_WAIT_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT_IDLE: if (r_cs_s2)  w_next = S_IDLE;
      S_IDLE:      if (!r_cs_s2) w_next = S_ACTIVE;
      S_ACTIVE:    if (r_cs_s2)  w_next = S_IDLE;
      default:     w_next = S_WAIT_IDLE;
    endcase
  end

  assign w_enter    = (r_state == S_IDLE) && !r_cs_s2;
  // A cs_n rise seen in the same cycle as an SCLK edge wins over the edge.
  assign w_in_frame = (r_state == S_ACTIVE) && !r_cs_s2;
  assign w_rise     = w_in_frame && r_sclk_s2 && !r_sclk_d;
  assign w_fall     = w_in_frame && !r_sclk_s2 && r_sclk_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_shift <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_rx_byte  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (!w_in_frame) begin
        // Partial bytes are simply abandoned; the next byte overwrites the shifter.
        r_bit_cnt <= 3'd0;
      end else if (w_rise) begin
        r_rx_shift <= {r_rx_shift[6:0], r_mosi_s2};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_rx_byte  <= {r_rx_shift[6:0], r_mosi_s2};
          r_rx_valid <= 1'b1;
        end
      end
    end
  end

  assign rx_valid     = r_rx_valid;
  assign rx_byte      = r_rx_byte;
  assign frame_active = (r_state == S_ACTIVE);

`ifdef SPI_PERIPHERAL_TX_EN
  logic [7:0] r_tx_buf;
  logic       r_tx_full;
  logic [7:0] r_tx_shift;
  logic       r_tx_underrun;
  logic       w_reload;

  // Byte slots start on frame entry and on each fall that follows a completed byte.
  assign w_reload = w_enter || (w_fall && (r_bit_cnt == 3'd0));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_buf      <= 8'h00;
      r_tx_full     <= 1'b0;
      r_tx_shift    <= 8'h00;
      r_tx_underrun <= 1'b0;
    end else begin
      r_tx_underrun <= 1'b0;
      if (w_reload) begin
        if (r_tx_full) begin
          r_tx_shift <= r_tx_buf;
          r_tx_full  <= 1'b0;
        end else begin
          r_tx_shift    <= IDLE_TX_BYTE;
          r_tx_underrun <= 1'b1;
        end
      end else if (w_fall) begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
      // Only accepted while empty, so it never collides with the drain above.
      if (tx_load && !r_tx_full) begin
        r_tx_buf  <= tx_byte;
        r_tx_full <= 1'b1;
      end
    end
  end

  assign spi_miso    = (r_state == S_ACTIVE) ? r_tx_shift[7] : 1'b0;
  assign tx_ready    = !r_tx_full;
  assign tx_underrun = r_tx_underrun;
`else
  logic w_unused_tx;
  assign w_unused_tx = ^{tx_byte, tx_load, w_enter};
  assign spi_miso    = 1'b0;
  assign tx_ready    = 1'b0;
  assign tx_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// tb/tb_spi_peripheral.sv - directed self-checking bench for spi_peripheral
module tb_spi_peripheral;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_ready;
  logic       tx_underrun;
  logic       frame_active;

  int checks = 0;
  int errors = 0;

  int         rx_count = 0;
  int         underrun_count = 0;
  int         miso_hi_count = 0;
  int         double_rv = 0;
  logic       prev_rv = 1'b0;
  logic [7:0] rx_q[$];

`ifdef SPI_PERIPHERAL_TX_EN
  localparam logic EXP_READY = 1'b1;
`else
  localparam logic EXP_READY = 1'b0;
`endif

  spi_peripheral #(.IDLE_TX_BYTE(8'hFF)) dut (
    .clk          (clk),
    .reset        (reset),
    .spi_sclk     (spi_sclk),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .tx_byte      (tx_byte),
    .tx_load      (tx_load),
    .tx_ready     (tx_ready),
    .tx_underrun  (tx_underrun),
    .frame_active (frame_active)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_count = rx_count + 1;
      rx_q.push_back(rx_byte);
    end
    if (rx_valid && prev_rv) double_rv = double_rv + 1;
    prev_rv = rx_valid;
    if (tx_underrun) underrun_count = underrun_count + 1;
    if (spi_miso) miso_hi_count = miso_hi_count + 1;
  end

  task automatic clear_mon();
    rx_count = 0;
    underrun_count = 0;
    miso_hi_count = 0;
    double_rv = 0;
    rx_q.delete();
  endtask

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    repeat (4) @(negedge clk);
    m = spi_miso;
    spi_sclk = 1'b1;
    repeat (4) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] d, output logic [7:0] m);
    logic mb;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(d[i], mb);
      m[i] = mb;
    end
  endtask

  task automatic begin_frame();
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // cs_n rises together with the final SCLK fall.
  task automatic end_frame();
    spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic check_one_byte(input string name, input logic [7:0] exp);
    checks++;
    if (rx_count !== 1) begin
      errors++;
      $display("FAIL %s count: got %0d expected 1", name, rx_count);
    end
    checks++;
    if (rx_q.size() < 1 || rx_q[0] !== exp) begin
      errors++;
      $display("FAIL %s byte: got %h expected %h", name, rx_byte, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (spi_miso !== 1'b0)     begin errors++; $display("FAIL reset_miso: got %b expected 0", spi_miso); end
    checks++; if (rx_valid !== 1'b0)     begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_byte !== 8'h00)     begin errors++; $display("FAIL reset_rx_byte: got %h expected 00", rx_byte); end
    checks++; if (tx_ready !== EXP_READY) begin errors++; $display("FAIL reset_tx_ready: got %b expected %b", tx_ready, EXP_READY); end
    checks++; if (tx_underrun !== 1'b0)  begin errors++; $display("FAIL reset_tx_underrun: got %b expected 0", tx_underrun); end
    checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL reset_frame_active: got %b expected 0", frame_active); end
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL idle_frame_active: got %b expected 0", frame_active); end
  endtask

  task automatic test_single_byte();
    logic [7:0] d;
    logic       mb;
    d = 8'hA5;
    clear_mon();
    begin_frame();
    for (int i = 7; i >= 1; i--) spi_bit(d[i], mb);
    spi_mosi = d[0];
    repeat (4) @(negedge clk);
    spi_sclk = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (rx_valid !== (k == 3)) begin
        errors++;
        $display("FAIL latency_cycle%0d: got rx_valid=%b expected %b", k, rx_valid, (k == 3));
      end
      if (k == 3) begin
        checks++;
        if (rx_byte !== 8'hA5) begin errors++; $display("FAIL latency_byte: got %h expected a5", rx_byte); end
      end
    end
    spi_sclk = 1'b0;
    end_frame();
    checks++;
    if (rx_count !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", rx_count); end
  endtask

  task automatic test_multi_byte();
    logic [7:0] bytes [4];
    logic [7:0] m;
    bytes[0] = 8'h01; bytes[1] = 8'h00; bytes[2] = 8'h00; bytes[3] = 8'h02;
    clear_mon();
    begin_frame();
    for (int b = 0; b < 4; b++) begin
      spi_byte(bytes[b], m);
      checks++;
      if (frame_active !== 1'b1) begin errors++; $display("FAIL multi_frame_active%0d: got %b expected 1", b, frame_active); end
    end
    end_frame();
    checks++;
    if (rx_count !== 4) begin errors++; $display("FAIL multi_count: got %0d expected 4", rx_count); end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (rx_q.size() <= b || rx_q[b] !== bytes[b]) begin
        errors++;
        $display("FAIL multi_byte%0d: got %h expected %h", b, (rx_q.size() > b) ? rx_q[b] : 8'hxx, bytes[b]);
      end
    end
    checks++;
    if (double_rv !== 0) begin errors++; $display("FAIL back_to_back: got %0d doubled pulses expected 0", double_rv); end
  endtask

  task automatic test_abort();
    logic       mb;
    logic [7:0] m;
    clear_mon();
    begin_frame();
    for (int i = 0; i < 5; i++) spi_bit(1'b1, mb);
    end_frame();
    checks++;
    if (rx_count !== 0) begin errors++; $display("FAIL abort_count: got %0d expected 0", rx_count); end
    clear_mon();
    begin_frame();
    spi_byte(8'h5A, m);
    end_frame();
    check_one_byte("abort_next", 8'h5A);
  endtask

  task automatic test_reset_mid_frame();
    logic       mb;
    logic [7:0] m;
    clear_mon();
    begin_frame();
    for (int i = 0; i < 3; i++) spi_bit(1'b1, mb);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 13; i++) spi_bit(i[0], mb);
    checks++;
    if (rx_count !== 0) begin errors++; $display("FAIL midreset_count: got %0d expected 0", rx_count); end
    checks++;
    if (frame_active !== 1'b0) begin errors++; $display("FAIL midreset_frame_active: got %b expected 0", frame_active); end
    end_frame();
    clear_mon();
    begin_frame();
    spi_byte(8'hC3, m);
    end_frame();
    check_one_byte("midreset_next", 8'hC3);
  endtask

`ifdef SPI_PERIPHERAL_TX_EN
  task automatic test_tx();
    logic [7:0] m0, m1;
    clear_mon();
    tx_byte = 8'h3C; tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL tx_ready_after_load: got %b expected 0", tx_ready); end
    tx_byte = 8'h99; tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    begin_frame();
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx_ready_after_entry: got %b expected 1", tx_ready); end
    checks++;
    if (underrun_count !== 0) begin errors++; $display("FAIL tx_underrun_entry: got %0d expected 0", underrun_count); end
    spi_byte(8'h11, m0);
    spi_byte(8'h22, m1);
    end_frame();
    checks++;
    if (m0 !== 8'h3C) begin errors++; $display("FAIL tx_byte0: got %h expected 3c", m0); end
    checks++;
    if (m1 !== 8'hFF) begin errors++; $display("FAIL tx_byte1: got %h expected ff", m1); end
    checks++;
    if (underrun_count !== 1) begin errors++; $display("FAIL tx_underrun_count: got %0d expected 1", underrun_count); end
    checks++;
    if (spi_miso !== 1'b0) begin errors++; $display("FAIL tx_miso_idle: got %b expected 0", spi_miso); end
  endtask
`else
  task automatic test_tx_disabled();
    logic [7:0] m;
    clear_mon();
    tx_byte = 8'h3C; tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL txdis_ready: got %b expected 0", tx_ready); end
    begin_frame();
    spi_byte(8'h96, m);
    end_frame();
    checks++;
    if (miso_hi_count !== 0 || m !== 8'h00) begin
      errors++;
      $display("FAIL txdis_miso: got %0d high cycles, byte %h expected 0 and 00", miso_hi_count, m);
    end
    checks++;
    if (underrun_count !== 0) begin errors++; $display("FAIL txdis_underrun: got %0d expected 0", underrun_count); end
    check_one_byte("txdis_rx", 8'h96);
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_multi_byte();
    test_abort();
    test_reset_mid_frame();
`ifdef SPI_PERIPHERAL_TX_EN
    test_tx();
`else
    test_tx_disabled();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
